cmp_threshold_monitor: RTL and testbench

- Downstream consumer of the 16-bit magnitude comparison (gt/eq/lt) result.
- Checks a stream of valid-qualified samples against programmable high and low thresholds.
- Debounces violations over consecutive valid samples and raises sticky high/low alarms, each with its own debounced clear.
- Sits between the sample datapath and the status/interrupt logic.

---
 rtl/cmp_threshold_monitor_pkg.sv | 26 ++
 rtl/cmp_threshold_monitor_mag_cmp_unit.sv | 17 +
 rtl/cmp_threshold_monitor.sv | 160 ++++++++++++++++
 tb/tb_cmp_threshold_monitor.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmp_threshold_monitor_pkg.sv
// Shared types and limits for the threshold monitor.
// State encoding is exported on state_o, so values are fixed.
package cmp_threshold_monitor_pkg;

  typedef enum logic [2:0] {
    ST_OK       = 3'd0,
    ST_HI_PEND  = 3'd1,
    ST_HI_ALARM = 3'd2,
    ST_LO_PEND  = 3'd3,
    ST_LO_ALARM = 3'd4
  } state_t;

  localparam int RUN_W   = 8;
  localparam int DEB_MIN = 1;
  localparam int DEB_MAX = 255;

  // Out-of-range debounce lengths are pinned to the legal range.
  function automatic logic [RUN_W-1:0] deb_clamp(input int d);
    int c;
    c = d;
    if (c < DEB_MIN) c = DEB_MIN;
    if (c > DEB_MAX) c = DEB_MAX;
    return c[RUN_W-1:0];
  endfunction

endpackage

// File: rtl/cmp_threshold_monitor_mag_cmp_unit.sv
// Unsigned magnitude comparator with gt/eq/lt flags.
// Instanced once per threshold by the monitor.
module mag_cmp_unit #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  assign gt = (a > b);
  assign eq = (a == b);
  assign lt = (a < b);

endmodule

// File: rtl/cmp_threshold_monitor.sv
// Debounced high/low threshold monitor with sticky alarms,
// change pulse and saturating alarm-entry counter.
module cmp_threshold_monitor
  import cmp_threshold_monitor_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int DEBOUNCE = 4,
  parameter int EVT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_valid,
  input  logic [WIDTH-1:0] sample,
  input  logic [WIDTH-1:0] th_hi,
  input  logic [WIDTH-1:0] th_lo,
  output logic             alarm_hi,
  output logic             alarm_lo,
  output logic             alarm_change,
  output logic [EVT_W-1:0] evt_cnt,
  output logic [2:0]       state_o
);

  localparam logic [RUN_W-1:0] DEB = deb_clamp(DEBOUNCE);
  localparam logic [RUN_W-1:0] ONE = RUN_W'(1);
  localparam logic [RUN_W-1:0] ZERO = '0;

  logic gt_hi, eq_hi, lt_hi;
  logic gt_lo, eq_lo, lt_lo;
  logic above, below;
  logic unused_cmp;

  state_t           state_q, state_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic [RUN_W-1:0] run_inc;
  logic             hit;
  logic             hi_d, lo_d;
  logic             entry;

  mag_cmp_unit #(.WIDTH(WIDTH)) u_cmp_hi (
    .a  (sample),
    .b  (th_hi),
    .gt (gt_hi),
    .eq (eq_hi),
    .lt (lt_hi)
  );

  mag_cmp_unit #(.WIDTH(WIDTH)) u_cmp_lo (
    .a  (sample),
    .b  (th_lo),
    .gt (gt_lo),
    .eq (eq_lo),
    .lt (lt_lo)
  );

  assign unused_cmp = ^{eq_hi, lt_hi, gt_lo, eq_lo};

  // Inverted thresholds can flag both; above wins.
  assign above = gt_hi;
  assign below = lt_lo & ~gt_hi;

  assign run_inc = run_q + ONE;
  assign hit     = (run_inc == DEB);

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    case (state_q)
      ST_OK: begin
        if (sample_valid) begin
          if (above) begin
            state_d = (DEB == ONE) ? ST_HI_ALARM : ST_HI_PEND;
            run_d   = (DEB == ONE) ? ZERO : ONE;
          end else if (below) begin
            state_d = (DEB == ONE) ? ST_LO_ALARM : ST_LO_PEND;
            run_d   = (DEB == ONE) ? ZERO : ONE;
          end
        end
      end
      ST_HI_PEND: begin
        if (sample_valid) begin
          if (above) begin
            state_d = hit ? ST_HI_ALARM : ST_HI_PEND;
            run_d   = hit ? ZERO : run_inc;
          end else if (below) begin
            state_d = ST_LO_PEND;
            run_d   = ONE;
          end else begin
            state_d = ST_OK;
            run_d   = ZERO;
          end
        end
      end
      ST_LO_PEND: begin
        if (sample_valid) begin
          if (below) begin
            state_d = hit ? ST_LO_ALARM : ST_LO_PEND;
            run_d   = hit ? ZERO : run_inc;
          end else if (above) begin
            state_d = ST_HI_PEND;
            run_d   = ONE;
          end else begin
            state_d = ST_OK;
            run_d   = ZERO;
          end
        end
      end
      ST_HI_ALARM: begin
        if (sample_valid) begin
          if (above) begin
            run_d = ZERO;
          end else begin
            state_d = hit ? ST_OK : ST_HI_ALARM;
            run_d   = hit ? ZERO : run_inc;
          end
        end
      end
      ST_LO_ALARM: begin
        if (sample_valid) begin
          if (below) begin
            run_d = ZERO;
          end else begin
            state_d = hit ? ST_OK : ST_LO_ALARM;
            run_d   = hit ? ZERO : run_inc;
          end
        end
      end
      default: begin
        state_d = ST_OK;
        run_d   = ZERO;
      end
    endcase
  end

  assign hi_d  = (state_d == ST_HI_ALARM);
  assign lo_d  = (state_d == ST_LO_ALARM);
  assign entry = (hi_d & ~alarm_hi) | (lo_d & ~alarm_lo);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_OK;
      run_q        <= '0;
      alarm_hi     <= 1'b0;
      alarm_lo     <= 1'b0;
      alarm_change <= 1'b0;
      evt_cnt      <= '0;
    end else begin
      state_q      <= state_d;
      run_q        <= run_d;
      alarm_hi     <= hi_d;
      alarm_lo     <= lo_d;
      alarm_change <= (hi_d ^ alarm_hi) | (lo_d ^ alarm_lo);
      if (entry && (evt_cnt != {EVT_W{1'b1}})) begin
        evt_cnt <= evt_cnt + EVT_W'(1);
      end
    end
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_cmp_threshold_monitor.sv
// Scoreboard bench for cmp_threshold_monitor: a reference model
// queues expected outputs per cycle; scenario tasks add direct checks.
module tb_cmp_threshold_monitor;

  localparam int DEB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sample_valid = 1'b0;
  logic [15:0] sample = '0;
  logic [15:0] th_hi = '0;
  logic [15:0] th_lo = '0;
  logic        alarm_hi;
  logic        alarm_lo;
  logic        alarm_change;
  logic [7:0]  evt_cnt;
  logic [2:0]  state_o;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic       hi;
    logic       lo;
    logic       chg;
    logic [7:0] evt;
    logic [2:0] st;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int m_st = 0;
  int m_run = 0;
  int m_evt = 0;

  cmp_threshold_monitor #(
    .WIDTH(16), .DEBOUNCE(DEB), .EVT_W(8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .sample       (sample),
    .th_hi        (th_hi),
    .th_lo        (th_lo),
    .alarm_hi     (alarm_hi),
    .alarm_lo     (alarm_lo),
    .alarm_change (alarm_change),
    .evt_cnt      (evt_cnt),
    .state_o      (state_o)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      checks++;
      if ({alarm_hi, alarm_lo, alarm_change, evt_cnt, state_o} !==
          {mon_e.hi, mon_e.lo, mon_e.chg, mon_e.evt, mon_e.st}) begin
        failures++;
        $display("FAIL scoreboard t=%0t got hi=%b lo=%b chg=%b evt=%0d st=%0d expected hi=%b lo=%b chg=%b evt=%0d st=%0d",
                 $time, alarm_hi, alarm_lo, alarm_change, evt_cnt, state_o,
                 mon_e.hi, mon_e.lo, mon_e.chg, mon_e.evt, mon_e.st);
      end
    end
  end

  task automatic model(input bit r, input bit v, input int s,
                       input int h, input int l);
    bit ab, bl, ph, pl;
    exp_t e;
    ph = (m_st == 2);
    pl = (m_st == 4);
    if (r) begin
      m_st = 0; m_run = 0; m_evt = 0;
    end else if (v) begin
      ab = (s > h);
      bl = !ab && (s < l);
      case (m_st)
        0: begin
          if (ab) begin m_st = 1; m_run = 1; end
          else if (bl) begin m_st = 3; m_run = 1; end
        end
        1: begin
          if (ab) begin
            m_run++;
            if (m_run == DEB) begin
              m_st = 2; m_run = 0;
              if (m_evt < 255) m_evt++;
            end
          end else if (bl) begin m_st = 3; m_run = 1; end
          else begin m_st = 0; m_run = 0; end
        end
        3: begin
          if (bl) begin
            m_run++;
            if (m_run == DEB) begin
              m_st = 4; m_run = 0;
              if (m_evt < 255) m_evt++;
            end
          end else if (ab) begin m_st = 1; m_run = 1; end
          else begin m_st = 0; m_run = 0; end
        end
        2: begin
          if (ab) m_run = 0;
          else begin
            m_run++;
            if (m_run == DEB) begin m_st = 0; m_run = 0; end
          end
        end
        default: begin
          if (bl) m_run = 0;
          else begin
            m_run++;
            if (m_run == DEB) begin m_st = 0; m_run = 0; end
          end
        end
      endcase
    end
    e.hi  = (m_st == 2);
    e.lo  = (m_st == 4);
    e.chg = r ? 1'b0 : ((e.hi != ph) || (e.lo != pl));
    e.evt = m_evt[7:0];
    e.st  = m_st[2:0];
    exp_q.push_back(e);
  endtask

  task automatic step(input bit r, input bit v, input int s,
                      input int h, input int l);
    @(negedge clk);
    rst = r;
    sample_valid = v;
    sample = s[15:0];
    th_hi = h[15:0];
    th_lo = l[15:0];
    model(r, v, s, h, l);
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    step(1, 0, 0, 100, 20);
    step(1, 0, 0, 100, 20);
    checks++;
    if ({alarm_hi, alarm_lo, alarm_change, evt_cnt, state_o} !== 13'd0) begin
      failures++;
      $display("FAIL reset_state got %b expected all zero",
               {alarm_hi, alarm_lo, alarm_change, evt_cnt, state_o});
    end
  endtask

  task automatic test_hi_alarm();
    test_reset();
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 150, 100, 20);
      if (i == 2) begin
        checks++;
        if (alarm_hi !== 1'b0) begin
          failures++;
          $display("FAIL hi_early got %b expected 0", alarm_hi);
        end
      end
    end
    checks++;
    if ({alarm_hi, alarm_change, evt_cnt, state_o} !== {1'b1, 1'b1, 8'd1, 3'd2}) begin
      failures++;
      $display("FAIL hi_alarm got hi=%b chg=%b evt=%0d st=%0d expected 1 1 1 2",
               alarm_hi, alarm_change, evt_cnt, state_o);
    end
    step(0, 0, 150, 100, 20);
    checks++;
    if (alarm_change !== 1'b0) begin
      failures++;
      $display("FAIL hi_chg_pulse got %b expected 0", alarm_change);
    end
  endtask

  task automatic test_broken_run();
    int seq[7] = '{150, 150, 150, 50, 150, 150, 150};
    bit seen = 0;
    test_reset();
    for (int i = 0; i < 7; i++) begin
      step(0, 1, seq[i], 100, 20);
      if (alarm_hi) seen = 1;
      if (i == 3) begin
        checks++;
        if (state_o !== 3'd0) begin
          failures++;
          $display("FAIL broken_state got %0d expected 0", state_o);
        end
      end
    end
    checks++;
    if (seen || state_o !== 3'd1) begin
      failures++;
      $display("FAIL broken_run got seen=%b st=%0d expected seen=0 st=1",
               seen, state_o);
    end
  endtask

  task automatic test_valid_gaps();
    test_reset();
    for (int i = 0; i < 7; i++) begin
      step(0, (i % 2) == 0, 10, 100, 20);
      if (i == 5) begin
        checks++;
        if (alarm_lo !== 1'b0 || state_o !== 3'd3) begin
          failures++;
          $display("FAIL gaps_pre got lo=%b st=%0d expected 0 3",
                   alarm_lo, state_o);
        end
      end
    end
    checks++;
    if ({alarm_lo, alarm_hi, alarm_change, state_o} !== {1'b1, 1'b0, 1'b1, 3'd4}) begin
      failures++;
      $display("FAIL gaps_alarm got lo=%b hi=%b chg=%b st=%0d expected 1 0 1 4",
               alarm_lo, alarm_hi, alarm_change, state_o);
    end
  endtask

  task automatic test_clear_path();
    int seq[7] = '{100, 100, 150, 100, 100, 100, 100};
    test_reset();
    for (int i = 0; i < 4; i++) step(0, 1, 150, 100, 20);
    for (int i = 0; i < 7; i++) begin
      step(0, 1, seq[i], 100, 20);
      if (i == 5) begin
        checks++;
        if (alarm_hi !== 1'b1) begin
          failures++;
          $display("FAIL clear_hold got %b expected 1", alarm_hi);
        end
      end
    end
    checks++;
    if ({alarm_hi, alarm_change, evt_cnt, state_o} !== {1'b0, 1'b1, 8'd1, 3'd0}) begin
      failures++;
      $display("FAIL clear_path got hi=%b chg=%b evt=%0d st=%0d expected 0 1 1 0",
               alarm_hi, alarm_change, evt_cnt, state_o);
    end
  endtask

  task automatic test_boundary();
    test_reset();
    step(0, 1, 20, 100, 20);
    step(0, 1, 100, 100, 20);
    checks++;
    if (state_o !== 3'd0) begin
      failures++;
      $display("FAIL boundary_eq got %0d expected 0", state_o);
    end
    for (int i = 0; i < 4; i++) step(0, 1, 150, 100, 200);
    checks++;
    if ({alarm_hi, alarm_lo, state_o} !== {1'b1, 1'b0, 3'd2}) begin
      failures++;
      $display("FAIL inverted got hi=%b lo=%b st=%0d expected 1 0 2",
               alarm_hi, alarm_lo, state_o);
    end
  endtask

  task automatic test_reset_mid();
    test_reset();
    for (int i = 0; i < 3; i++) step(0, 1, 150, 100, 20);
    step(1, 1, 150, 100, 20);
    checks++;
    if ({alarm_hi, alarm_lo, alarm_change, evt_cnt, state_o} !== 13'd0) begin
      failures++;
      $display("FAIL reset_mid got %b expected all zero",
               {alarm_hi, alarm_lo, alarm_change, evt_cnt, state_o});
    end
    step(0, 1, 150, 100, 20);
    checks++;
    if (state_o !== 3'd1 || alarm_hi !== 1'b0) begin
      failures++;
      $display("FAIL reset_resume got st=%0d hi=%b expected 1 0",
               state_o, alarm_hi);
    end
  endtask

  task automatic test_back_to_back();
    test_reset();
    for (int i = 0; i < 3; i++) step(0, 1, 150, 100, 20);
    step(0, 1, 10, 100, 20);
    checks++;
    if (state_o !== 3'd3) begin
      failures++;
      $display("FAIL hi_to_lo got %0d expected 3", state_o);
    end
    for (int i = 0; i < 3; i++) step(0, 1, 10, 100, 20);
    for (int i = 0; i < 4; i++) step(0, 1, 150, 100, 20);
    checks++;
    if ({alarm_lo, alarm_hi, evt_cnt, state_o} !== {1'b0, 1'b0, 8'd1, 3'd0}) begin
      failures++;
      $display("FAIL lo_clear_by_above got lo=%b hi=%b evt=%0d st=%0d expected 0 0 1 0",
               alarm_lo, alarm_hi, evt_cnt, state_o);
    end
  endtask

  task automatic test_evt_saturate();
    test_reset();
    for (int n = 0; n < 258; n++) begin
      for (int i = 0; i < 4; i++) step(0, 1, 150, 100, 20);
      for (int i = 0; i < 4; i++) step(0, 1, 50, 100, 20);
    end
    checks++;
    if (evt_cnt !== 8'd255 || state_o !== 3'd0) begin
      failures++;
      $display("FAIL evt_saturate got evt=%0d st=%0d expected 255 0",
               evt_cnt, state_o);
    end
  endtask

  task automatic test_random();
    int h, l;
    test_reset();
    h = 120; l = 60;
    for (int i = 0; i < 600; i++) begin
      if (i % 60 == 0) begin
        h = $urandom_range(160, 80);
        l = $urandom_range(120, 40);
      end
      step(($urandom_range(99, 0) == 0), ($urandom_range(3, 0) != 0),
           $urandom_range(255, 0), h, l);
    end
  endtask

  initial begin
    test_reset();
    test_hi_alarm();
    test_broken_run();
    test_valid_gaps();
    test_clear_path();
    test_boundary();
    test_reset_mid();
    test_back_to_back();
    test_evt_saturate();
    test_random();
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got %0d pending expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
